// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// instruction classes, ALUOp and PCSrc codes.
package mc_ctrl_pkg;

    // Opcode field values
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b011100;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_BLTZ = 6'b110010;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Next-PC source select
    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    // FSM states; low three bits are the debug code, HALT is internal only
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    // Instruction classes produced by the decoder
    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_BRANCH  = 3'd1;
    localparam logic [2:0] CLS_LS      = 3'd2;
    localparam logic [2:0] CLS_JUMP    = 3'd3;
    localparam logic [2:0] CLS_HALT    = 3'd4;
    localparam logic [2:0] CLS_ILLEGAL = 3'd5;

    // Debug state code: HALT reports as ID
    function automatic logic [2:0] state_code(input state_e s);
        return (s == S_HALT) ? 3'b001 : s[2:0];
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// mc_decode: opcode -> instruction class plus the state-independent
// datapath controls. The FSM decides when these reach the datapath.
import mc_ctrl_pkg::*;

module mc_decode (
    input  logic [5:0] opcode,
    output logic [2:0] cls,
    output logic       is_load,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic [2:0] alu_op
);

    // Static control table; unknown opcodes decode as ILLEGAL with all controls low
    always_comb begin
        cls       = CLS_ILLEGAL;
        is_load   = 1'b0;
        reg_dst   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_ADD:  begin cls = CLS_ALU; reg_dst = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CLS_ALU; reg_dst = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CLS_ALU; reg_dst = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin cls = CLS_ALU; reg_dst = 1'b1; alu_op = ALU_OR;  end
            OP_SLL:  begin cls = CLS_ALU; reg_dst = 1'b1; alu_src_a = 1'b1; alu_op = ALU_SLL; end
            OP_ADDI: begin cls = CLS_ALU; alu_src_b = 1'b1; ext_sel = 1'b1; alu_op = ALU_ADD; end
            OP_ORI:  begin cls = CLS_ALU; alu_src_b = 1'b1; alu_op = ALU_OR; end
            OP_SLTI: begin cls = CLS_ALU; alu_src_b = 1'b1; ext_sel = 1'b1; alu_op = ALU_SLT; end
            OP_SW:   begin cls = CLS_LS; alu_src_b = 1'b1; ext_sel = 1'b1; alu_op = ALU_ADD; end
            OP_LW:   begin cls = CLS_LS; is_load = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; alu_op = ALU_ADD; end
            // Branches compare via subtract; BLTZ subtracts $0 (rt) and looks at sign
            OP_BEQ, OP_BNE, OP_BLTZ: begin cls = CLS_BRANCH; ext_sel = 1'b1; alu_op = ALU_SUB; end
            OP_J:    cls = CLS_JUMP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: IF/ID/EXE/MEM/WB sequencer driving the datapath strobes.
// Optional performance counters (cycle_cnt, instr_cnt) when
// MULTI_CYCLE_PERF_EN is defined.
import mc_ctrl_pkg::*;

module multi_cycle_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        sign,
    input  logic        mem_ready,
    output logic        PCWre,
    output logic        IRWre,
    output logic        RegDst,
    output logic        RegWre,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        nRD,
    output logic        nWR,
    output logic        DBDataSrc,
    output logic [2:0]  state,
`ifdef MULTI_CYCLE_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    output logic        halted,
    output logic        illegal
);

    state_e st, nxt;

    logic [2:0] cls;
    logic       is_load, dec_reg_dst, dec_src_a, dec_src_b, dec_ext, taken;
    logic [2:0] dec_alu_op;

    mc_decode u_decode (
        .opcode    (Opcode),
        .cls       (cls),
        .is_load   (is_load),
        .reg_dst   (dec_reg_dst),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext),
        .alu_op    (dec_alu_op)
    );

    assign state = state_code(st);

    // Branch condition selected by the specific branch opcode
    always_comb begin
        taken = 1'b0;
        case (Opcode)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = ~zero;
            OP_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
    end

    // State register; reset always lands in IF, aborting any instruction
    always_ff @(posedge CLK) begin
        if (Reset) st <= S_IF;
        else       st <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = st;
        case (st)
            S_IF: nxt = S_ID;
            S_ID: begin
                case (cls)
                    CLS_ALU:    nxt = S_EXE_AL;
                    CLS_BRANCH: nxt = S_EXE_BR;
                    CLS_LS:     nxt = S_EXE_LS;
                    CLS_HALT:   nxt = S_HALT;
                    default:    nxt = S_IF;
                endcase
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL:  nxt = S_IF;
            S_EXE_BR: nxt = S_IF;
            S_EXE_LS: nxt = S_MEM;
            S_MEM: begin
                if (mem_ready) nxt = is_load ? S_WB_LD : S_IF;
            end
            S_WB_LD: nxt = S_IF;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

    // Datapath strobes; all forced to idle values while Reset is high.
    // Static controls are presented from EXE through the end of the instruction.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegDst    = 1'b0;
        RegWre    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        PCSrc     = PCSRC_SEQ;
        nRD       = 1'b1;
        nWR       = 1'b1;
        DBDataSrc = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        if (!Reset) begin
            if (st == S_EXE_AL || st == S_WB_AL || st == S_EXE_BR ||
                st == S_EXE_LS || st == S_MEM   || st == S_WB_LD) begin
                RegDst  = dec_reg_dst;
                ALUSrcA = dec_src_a;
                ALUSrcB = dec_src_b;
                ExtSel  = dec_ext;
                ALUOp   = dec_alu_op;
            end
            case (st)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (cls == CLS_JUMP) begin
                        PCWre = 1'b1;
                        PCSrc = PCSRC_JUMP;
                    end else if (cls == CLS_ILLEGAL) begin
                        PCWre   = 1'b1;
                        illegal = 1'b1;
                    end
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    if (taken) PCSrc = PCSRC_BR;
                end
                S_WB_AL: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                S_MEM: begin
                    if (is_load) nRD = 1'b0;
                    else begin
                        nWR   = 1'b0;
                        PCWre = mem_ready;
                    end
                end
                S_WB_LD: begin
                    nRD       = 1'b0;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    PCWre     = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTI_CYCLE_PERF_EN
    // Cycle and retired-instruction counters, free-running modulo 2^32
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (st != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (PCWre)        instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed-vector bench for multi_cycle_ctrl: one row per clock cycle.
module tb_multi_cycle_ctrl;
    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic       zero, sign, mem_ready;
    logic       PCWre, IRWre, RegDst, RegWre, ALUSrcA, ALUSrcB, ExtSel;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic       nRD, nWR, DBDataSrc;
    logic [2:0] state;
    logic       halted, illegal;
`ifdef MULTI_CYCLE_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multi_cycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .sign(sign),
        .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre), .RegDst(RegDst),
        .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .nRD(nRD), .nWR(nWR), .DBDataSrc(DBDataSrc),
        .state(state),
`ifdef MULTI_CYCLE_PERF_EN
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
        .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    localparam logic [5:0] ADD = 6'b000000, ORI = 6'b010000, SW = 6'b100110,
                           LW = 6'b100111, BEQ = 6'b110000, BLTZ = 6'b110010,
                           J = 6'b111000, HLT = 6'b111111, ILL = 6'b101010;

    // exp layout: {state,PCWre,IRWre,RegWre,RegDst,ALUSrcA,ALUSrcB,ExtSel,ALUOp,PCSrc,nRD,nWR,DBDataSrc,halted,illegal}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z, s, rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic z,
                                input logic s, input logic rdy, input logic [2:0] st,
                                input logic pcw, input logic irw, input logic rgw,
                                input logic rd, input logic sa, input logic sb,
                                input logic ext, input logic [2:0] aop,
                                input logic [1:0] pcs, input logic nrd, input logic nwr,
                                input logic db, input logic h, input logic il);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.s = s; v.rdy = rdy;
        v.exp = {st, pcw, irw, rgw, rd, sa, sb, ext, aop, pcs, nrd, nwr, db, h, il};
        return v;
    endfunction

    function automatic logic [19:0] actual();
        return {state, PCWre, IRWre, RegWre, RegDst, ALUSrcA, ALUSrcB, ExtSel,
                ALUOp, PCSrc, nRD, nWR, DBDataSrc, halted, illegal};
    endfunction

    task automatic drive(input logic rst, input logic [5:0] op, input logic z,
                         input logic s, input logic rdy);
        Reset = rst; Opcode = op; zero = z; sign = s; mem_ready = rdy;
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //            rst op   z s r  st     pw iw rw rd sa sb ex aop     pcs    nr nw db h il
        vecs.push_back(mk(1, ADD, 0,0,1, 3'd0, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(1, ADD, 0,0,1, 3'd0, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        // ADD: 000,001,110,111
        vecs.push_back(mk(0, ADD, 0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ADD, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ADD, 0,0,1, 3'd6, 0,0,0,1,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ADD, 0,0,1, 3'd7, 1,0,1,1,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        // BEQ taken
        vecs.push_back(mk(0, BEQ, 1,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, BEQ, 1,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, BEQ, 1,0,1, 3'd5, 1,0,0,0,0,0,1,3'b001,2'b01, 1,1,0,0,0));
        // BEQ not taken
        vecs.push_back(mk(0, BEQ, 0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, BEQ, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, BEQ, 0,0,1, 3'd5, 1,0,0,0,0,0,1,3'b001,2'b00, 1,1,0,0,0));
        // LW with three wait cycles: 8 cycles total
        vecs.push_back(mk(0, LW,  0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,1, 3'd2, 0,0,0,0,0,1,1,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,0, 3'd3, 0,0,0,0,0,1,1,3'b000,2'b00, 0,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,0, 3'd3, 0,0,0,0,0,1,1,3'b000,2'b00, 0,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,0, 3'd3, 0,0,0,0,0,1,1,3'b000,2'b00, 0,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,1, 3'd3, 0,0,0,0,0,1,1,3'b000,2'b00, 0,1,0,0,0));
        vecs.push_back(mk(0, LW,  0,0,1, 3'd4, 1,0,1,0,0,1,1,3'b000,2'b00, 0,1,1,0,0));
        // illegal opcode behaves as a 2-cycle NOP
        vecs.push_back(mk(0, ILL, 0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ILL, 0,0,1, 3'd1, 1,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,1));
        // J
        vecs.push_back(mk(0, J,   0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, J,   0,0,1, 3'd1, 1,0,0,0,0,0,0,3'b000,2'b10, 1,1,0,0,0));
        // SW aborted by Reset in second MEM wait cycle
        vecs.push_back(mk(0, SW,  0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,1, 3'd2, 0,0,0,0,0,1,1,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,0, 3'd3, 0,0,0,0,0,1,1,3'b000,2'b00, 1,0,0,0,0));
        vecs.push_back(mk(1, SW,  0,0,0, 3'd3, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        // SW again, one wait cycle, write completes once
        vecs.push_back(mk(0, SW,  0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,1, 3'd2, 0,0,0,0,0,1,1,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,0, 3'd3, 0,0,0,0,0,1,1,3'b000,2'b00, 1,0,0,0,0));
        vecs.push_back(mk(0, SW,  0,0,1, 3'd3, 1,0,0,0,0,1,1,3'b000,2'b00, 1,0,0,0,0));
        // HALT, then reset out of it
        vecs.push_back(mk(0, HLT, 0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, HLT, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, HLT, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,1,0));
        vecs.push_back(mk(0, ADD, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,1,0));
        vecs.push_back(mk(1, ADD, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        // BLTZ taken on sign
        vecs.push_back(mk(0, BLTZ,0,1,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, BLTZ,0,1,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, BLTZ,0,1,1, 3'd5, 1,0,0,0,0,0,1,3'b001,2'b01, 1,1,0,0,0));
        // ORI: zero-extend, immediate, OR
        vecs.push_back(mk(0, ORI, 0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ORI, 0,0,1, 3'd1, 0,0,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ORI, 0,0,1, 3'd6, 0,0,0,0,0,1,0,3'b011,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ORI, 0,0,1, 3'd7, 1,0,1,0,0,1,0,3'b011,2'b00, 1,1,0,0,0));
        vecs.push_back(mk(0, ORI, 0,0,1, 3'd0, 0,1,0,0,0,0,0,3'b000,2'b00, 1,1,0,0,0));

        drive(1, ADD, 0, 0, 1);
        @(posedge CLK);
        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].s, vecs[i].rdy);
            #1;
            n_vec++;
            if (actual() !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL vec%0d: got %b expected %b", i, actual(), vecs[i].exp);
            end
        end

        // HALT must hold with no PC update indefinitely
        @(negedge CLK); drive(1, HLT, 0, 0, 1);
        @(negedge CLK); drive(0, HLT, 0, 0, 1);
        @(negedge CLK);
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK); #1;
            check1("halt_hold", {29'd0, state, 1'b0} | {31'd0, PCWre} | {30'd0, halted, 1'b0},
                   {29'd0, 3'b001, 1'b0} | {30'd0, 1'b1, 1'b0});
        end

`ifdef MULTI_CYCLE_PERF_EN
        // J (2) + ADD (4) + LW w=0 (5) = 11 cycles, 3 instructions
        @(negedge CLK); drive(1, J, 0, 0, 1);
        for (int k = 0; k < 11; k++) begin
            @(negedge CLK);
            drive(0, (k < 2) ? J : ((k < 6) ? ADD : LW), 0, 0, 1);
        end
        @(negedge CLK); drive(1, J, 0, 0, 1); #1;
        check1("cycle_cnt", cycle_cnt, 32'd11);
        check1("instr_cnt", instr_cnt, 32'd3);
        @(negedge CLK); drive(0, J, 0, 0, 1); #1;
        check1("cnt_reset", cycle_cnt | instr_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle sequencer for the CPU datapath: replaces the single-cycle control unit with a state machine that steps each instruction through IF/ID/EXE/MEM/WB. It drives the same datapath strobes as before (PC, register file, ALU muxes, extender, data memory, write-back mux) plus an instruction-register enable. It also stalls in MEM on a data-memory ready handshake and stops on HALT.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; one clock, one reset domain.
- Opcode  in  6  opcode field from the instruction register.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result bit 31.
- mem_ready  in  1  data memory has completed the access this cycle.
- PCWre  out  1  PC load enable.
- IRWre  out  1  instruction-register load enable.
- RegDst  out  1  0 = rt, 1 = rd as write register.
- RegWre  out  1  register-file write enable.
- ALUSrcA  out  1  0 = rs data, 1 = zero-extended sa.
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate.
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 signed less-than.
- PCSrc  out  2  00 PC+4, 01 PC+4+offset, 10 jump target.
- nRD  out  1  data-memory read, active-low.
- nWR  out  1  data-memory write, active-low.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- state  out  3  current state code, for debug.
- halted  out  1  HALT executed.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: ADD 000000, ADDI 000001, SUB 000010, ORI 010000, AND 010001, OR 010010, SLL 011000, SLTI 011100, SW 100110, LW 100111, BEQ 110000, BNE 110001, BLTZ 110010, J 111000, HALT 111111.
- State codes: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111, plus internal HALT (reported on `state` as 001, with `halted`=1).
- Transitions:
  - IF→ID.
  - ID→EXE_AL for ADD/ADDI/SUB/ORI/AND/OR/SLL/SLTI.
  - ID→EXE_BR for BEQ/BNE/BLTZ.
  - ID→EXE_LS for SW/LW.
  - ID→IF for J and illegal opcodes.
  - ID→HALT for HALT.
  - EXE_AL→WB_AL→IF.
  - EXE_BR→IF.
  - EXE_LS→MEM.
  - MEM→MEM while mem_ready=0.
  - MEM→IF on SW; MEM→WB_LD on LW.
  - WB_LD→IF.
  - HALT holds until Reset.
- IRWre=1 only in IF. PCWre=1 only in the final state of each instruction (WB_AL, EXE_BR, MEM-with-ready for SW, WB_LD, ID for J/illegal). The PC therefore advances exactly once per instruction.
- PCSrc:
  - 10 in ID for J.
  - 01 in EXE_BR when taken: BEQ zero=1, BNE zero=0, BLTZ sign=1.
  - 00 otherwise.
- ExtSel=1 for ADDI, SLTI, SW, LW, BEQ/BNE/BLTZ; 0 for ORI.
- ALUSrcB=1 for immediate forms and SW/LW. ALUSrcA=1 only for SLL. RegDst=1 for R-type.
- ALUOp is held stable through EXE and all following states of the instruction.
- BLTZ uses sub with the rt register ($0) as operand B.
- RegWre=1 only in WB_AL and WB_LD.
- nWR=0 only in MEM for SW. nRD=0 in MEM and WB_LD for LW. DBDataSrc=1 in WB_LD.
- illegal pulses in ID; the instruction then behaves as a NOP.

## Timing
- Cycles per instruction: J and illegal 2; branches 3; R-type and immediate 4; SW 4+w; LW 5+w (w = MEM wait cycles).
- Outputs are combinational from the registered state plus Opcode/zero/sign/mem_ready.
- While Reset=1, outputs are forced to reset values: PCWre, IRWre, RegWre, RegDst, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc = 0; nRD = nWR = 1; PCSrc = 00; ALUOp = 000; halted = 0; illegal = 0.
- The clock edge with Reset=1 loads IF. Reset in any state, including MEM mid-wait or HALT, aborts the instruction with no PC or register write.
- mem_ready falling during a SW wait holds nWR=0 continuously until ready. A write completes exactly once.

## Configuration
- MULTI_CYCLE_PERF_EN defined: adds outputs cycle_cnt (32) and instr_cnt (32).
  - Both cleared by Reset.
  - cycle_cnt increments every non-HALT cycle.
  - instr_cnt increments on every PCWre=1 cycle.
  - Both wrap at 2^32.
- Not defined: these ports and counters are absent; the rest of the block is identical.

## Structure
- Package mc_ctrl_pkg holds the opcode constants, state encodings, ALUOp and PCSrc encodings. Shared with the ALU and the top-level.
- One sub-module: mc_decode.
  - Opcode → instruction class (ALU, BRANCH, LS, JUMP, HALT, ILLEGAL).
  - Static controls: RegDst, ALUSrcA, ALUSrcB, ExtSel, ALUOp.
  - The FSM gates these by state.

## Test plan
- Reset held 2 cycles, then ADD (000000) → states 000,001,110,111,000; RegWre=1 only in 111; PCWre=1 only in 111; RegDst=1.
- BEQ with zero=1 → PCSrc=01 and PCWre=1 in state 101. Repeat with zero=0 → PCSrc=00.
- LW with mem_ready low 3 cycles → MEM held 3 extra cycles with nRD=0; then WB_LD with DBDataSrc=1, RegWre=1. Total 8 cycles.
- SW, with Reset asserted during the second MEM wait cycle → next state IF; no PCWre; nWR returns to 1.
- Opcode 101010 → illegal=1 in ID, PCWre=1, PCSrc=00, back to IF after 2 cycles. HALT → halted=1 and PCWre=0 indefinitely until Reset.
- With MULTI_CYCLE_PERF_EN: J, ADD, LW(w=0) → instr_cnt=3, cycle_cnt=11.
